// File: rtl/ysyx_22040729_seq_divider.sv
// Sequential radix-2 restoring divider, signed/unsigned, 64- or 32-bit (word) operation.
// Build option YSYX_22040729_DIV_FASTPATH_EN: divide-by-zero and signed overflow finish on the accepting edge.
module ysyx_22040729_seq_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             is_word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

`ifdef YSYX_22040729_DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_WORD = WIDTH'(32'h8000_0000);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] part_rem, quo, dsr, q_out, r_out;
    logic             neg_q, neg_r, zero_r, ovf_r, word_r;

    logic [WIDTH-1:0] dd_ext, ds_ext, dd_mag, ds_mag;
    logic             dd_neg, ds_neg, in_zero, in_ovf;
    logic             accept, last, fast_go;

    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] iter_rem, iter_quo;

    // Sign handling and special-case overrides applied to the magnitude results.
    function automatic logic [2*WIDTH-1:0] finalize(
        input logic [WIDTH-1:0] q_mag,
        input logic [WIDTH-1:0] r_mag,
        input logic             nq,
        input logic             nr,
        input logic             zero,
        input logic             ovf,
        input logic             word
    );
        logic [WIDTH-1:0] q, r;
        q = nq ? -q_mag : q_mag;
        r = nr ? -r_mag : r_mag;
        if (zero) begin
            q = '1;
        end
        if (ovf) begin
            q = word ? MIN_WORD : MIN_FULL;
            r = '0;
        end
        if (word) begin
            q = {{(WIDTH-32){q[31]}}, q[31:0]};
            r = {{(WIDTH-32){r[31]}}, r[31:0]};
        end
        return {q, r};
    endfunction

    always_comb begin
        dd_ext = dividend;
        ds_ext = divisor;
        if (is_word) begin
            dd_ext = {{(WIDTH-32){is_signed & dividend[31]}}, dividend[31:0]};
            ds_ext = {{(WIDTH-32){is_signed & divisor[31]}}, divisor[31:0]};
        end
    end

    assign dd_neg  = is_signed & dd_ext[WIDTH-1];
    assign ds_neg  = is_signed & ds_ext[WIDTH-1];
    assign dd_mag  = dd_neg ? -dd_ext : dd_ext;
    assign ds_mag  = ds_neg ? -ds_ext : ds_ext;
    assign in_zero = (ds_ext == '0);
    assign in_ovf  = is_signed && (&ds_ext) &&
                     (is_word ? (dividend[31:0] == 32'h8000_0000) : (dd_ext == MIN_FULL));

    assign accept  = (state == IDLE) && in_valid && !flush;
    assign last    = (cnt == CNT_W'(WIDTH-1));
    assign fast_go = FAST && (in_zero || in_ovf);

    // Borrow out of the WIDTH+1-bit subtract is the "does not fit" indication.
    assign shifted  = {part_rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dsr};
    assign iter_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign iter_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = fast_go ? DONE : BUSY;
            BUSY: if (last) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // With a zero divisor every step subtracts nothing, so part_rem ends as the dividend magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            part_rem <= '0;
            quo      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            word_r   <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt      <= '0;
            part_rem <= '0;
            quo      <= dd_mag;
            dsr      <= ds_mag;
            neg_q    <= dd_neg ^ ds_neg;
            neg_r    <= dd_neg;
            zero_r   <= in_zero;
            ovf_r    <= in_ovf;
            word_r   <= is_word;
            if (fast_go) begin
                {q_out, r_out} <= finalize('0, dd_mag, dd_neg ^ ds_neg, dd_neg,
                                           in_zero, in_ovf, is_word);
            end
        end else if (state == BUSY) begin
            part_rem <= iter_rem;
            quo      <= iter_quo;
            cnt      <= cnt + 1'b1;
            if (last) begin
                {q_out, r_out} <= finalize(iter_quo, iter_rem, neg_q, neg_r,
                                           zero_r, ovf_r, word_r);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = q_out;
    assign remainder = r_out;

endmodule

// File: tb/tb_ysyx_22040729_seq_divider.sv
// Self-checking bench for ysyx_22040729_seq_divider: directed table, random ops vs an arithmetic model,
// and flush / reset / backpressure sequences.
module tb_ysyx_22040729_seq_divider;

`ifdef YSYX_22040729_DIV_FASTPATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 65;
`endif
    localparam int FULL_LAT = 65;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        is_word = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] dd;
        logic [63:0] ds;
        logic        sgn;
        logic        word;
        logic [63:0] eq;
        logic [63:0] er;
        int          elat;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    ysyx_22040729_seq_divider #(.WIDTH(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .is_word   (is_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Reference: plain SV arithmetic on the architectural operands.
    function automatic void model(input logic [63:0] dd, input logic [63:0] ds,
                                  input logic sgn, input logic word,
                                  output logic [63:0] q, output logic [63:0] r, output int lat);
        logic [63:0] a, b;
        longint      sa, sb;
        logic        special;
        a = word ? (sgn ? sext32(dd) : {32'h0, dd[31:0]}) : dd;
        b = word ? (sgn ? sext32(ds) : {32'h0, ds[31:0]}) : ds;
        special = 1'b0;
        if (b == 64'd0) begin
            q = '1;
            r = a;
            special = 1'b1;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = '0;
            special = 1'b1;
        end else if (sgn) begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
            if (word && a == 64'hFFFF_FFFF_8000_0000 && b == '1) special = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        if (word) begin
            q = sext32(q);
            r = sext32(r);
        end
        lat = special ? FAST_LAT : FULL_LAT;
    endfunction

    task automatic do_op(input vec_t v, input string name);
        int lat;
        logic [63:0] q0, r0;
        @(negedge clk);
        check({name, ".in_ready_idle"}, {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        dividend  = v.dd;
        divisor   = v.ds;
        is_signed = v.sgn;
        is_word   = v.word;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        is_signed = 1'($urandom_range(0, 1));
        is_word   = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check({name, ".latency"}, 64'(lat), 64'(v.elat));
        check({name, ".quotient"}, quotient, v.eq);
        check({name, ".remainder"}, remainder, v.er);
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_state"}, {61'd0, out_valid, in_ready, (quotient == q0 && remainder == r0)},
                  64'b101);
        end
        @(negedge clk);
        check({name, ".in_ready_before_hs"}, {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, ".after_hs"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic watch_no_result(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen++;
        end
        check({name, ".no_result"}, 64'(seen), 64'd0);
    endtask

    task automatic start_long_op();
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = 64'd100;
        divisor   = 64'd7;
        is_signed = 1'b0;
        is_word   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
    endtask

    initial begin
        vec_t v;
        logic [63:0] q, r;
        int lat;

        vecs.push_back('{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, FULL_LAT, 0});
        vecs.push_back('{-64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, FULL_LAT, 0});
        vecs.push_back('{64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, FAST_LAT, 0});
        vecs.push_back('{64'd5, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, FAST_LAT, 0});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                         64'h8000_0000_0000_0000, 64'd0, FAST_LAT, 0});
        vecs.push_back('{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
                         64'hFFFF_FFFF_8000_0000, 64'd0, FAST_LAT, 0});
        vecs.push_back('{64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 1'b1, 1'b1,
                         64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, FULL_LAT, 0});
        vecs.push_back('{64'hAAAA_AAAA_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
                         64'hFFFF_FFFF_FFFF_FFFF, 64'd0, FULL_LAT, 0});
        vecs.push_back('{64'd7, 64'd100, 1'b0, 1'b0, 64'd0, 64'd7, FULL_LAT, 0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0,
                         64'h5555_5555_5555_5555, 64'd0, FULL_LAT, 5});
        vecs.push_back('{64'd7, -64'sd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, FULL_LAT, 0});

        #1;
        check("reset.outputs", {out_valid, in_ready, quotient[30:0], remainder[30:0]}, 64'h4000_0000_0000_0000);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            v.dd   = {$urandom, $urandom};
            v.ds   = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 50)) : {$urandom, $urandom} >> $urandom_range(0, 60);
            v.sgn  = 1'($urandom_range(0, 1));
            v.word = 1'($urandom_range(0, 1));
            v.hold = $urandom_range(0, 2);
            model(v.dd, v.ds, v.sgn, v.word, q, r, lat);
            v.eq = q;
            v.er = r;
            v.elat = lat;
            do_op(v, $sformatf("rnd%0d", i));
        end

        start_long_op();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush.state", {62'd0, out_valid, in_ready}, 64'b01);
        watch_no_result("flush", 80);

        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_prio.in_ready", {63'd0, in_ready}, 64'd1);
        watch_no_result("flush_prio", 70);

        start_long_op();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.outputs", {62'd0, out_valid, in_ready}, 64'b01);
        check("midreset.quotient", quotient, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_result("midreset", 80);

        v = '{64'd1000, 64'd10, 1'b0, 1'b0, 64'd100, 64'd0, FULL_LAT, 1};
        do_op(v, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040729_seq_divider.md
YSYX_22040729_SEQ_DIVIDER -- requirements
Module: ysyx_22040729_seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width (even, >= 8).
REQ-002 SHALL have parameter CNT_W, default 7: iteration counter width, >= clog2(WIDTH+1).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: request valid.
REQ-006 SHALL have port in_ready, output, 1: divider can accept a request.
REQ-007 SHALL have port dividend, input, WIDTH: dividend.
REQ-008 SHALL have port divisor, input, WIDTH: divisor.
REQ-009 SHALL have port is_signed, input, 1: two's-complement operation.
REQ-010 SHALL have port is_word, input, 1: 32-bit operation on the low halves, result sign-extended.
REQ-011 SHALL have port flush, input, 1: abort the current operation.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port quotient, output, WIDTH: quotient.
REQ-015 SHALL have port remainder, output, WIDTH: remainder.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 SHALL accept a request on a rising edge with in_valid && in_ready && !flush, latching all operands and modes.
REQ-018 SHALL, when is_word=1, use dividend[31:0] and divisor[31:0], sign- or zero-extended per is_signed.
REQ-019 SHALL, when is_signed=1, convert operands to magnitudes at acceptance and record the result signs.
REQ-020 SHALL compute one quotient bit per BUSY cycle by radix-2 restoring shift/compare/subtract on magnitudes, using a WIDTH+1-bit partial remainder with no loss of carry.
REQ-021 SHALL perform exactly WIDTH iterations; BUSY->DONE on the edge completing the last iteration; out_valid asserts after WIDTH+1 rising edges counting the accepting edge.
REQ-022 SHALL negate the quotient when the operand signs differ and give the remainder the sign of the dividend (signed mode only).
REQ-023 SHALL, on divisor==0, produce quotient all ones and remainder = dividend (after word extension).
REQ-024 SHALL, on signed overflow (most-negative / -1), produce quotient = most-negative and remainder = 0.
REQ-025 SHALL, when is_word=1, sign-extend bit 31 of both final results to WIDTH bits, regardless of is_signed.
REQ-026 SHALL hold quotient/remainder stable in DONE until out_valid && out_ready, then go to IDLE on that edge.
REQ-027 SHALL not accept a new request in the same cycle that a result is consumed; in_ready rises the following cycle.
REQ-028 SHALL, on flush=1 in any state, go to IDLE on the next edge and discard the result; flush has priority over acceptance and completion.
REQ-029 SHALL ignore in_valid and operand changes while BUSY or DONE.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force IDLE, counter 0, quotient 0, remainder 0, out_valid 0 and in_ready 1.
REQ-031 SHALL, on reset mid-operation, abandon the operation; no result is produced after reset releases.

Configuration
REQ-032 SHALL provide the macro YSYX_22040729_DIV_FASTPATH_EN.
- Defined: divide-by-zero and signed overflow go IDLE->DONE on the accepting edge, so out_valid is high on the following cycle.
- Undefined: these cases take the full WIDTH-iteration BUSY sequence, with results still per REQ-023/024.
- Results are identical either way; only latency differs.

Verification (WIDTH=64)
REQ-033 SHALL cover: unsigned 100/7 -> quotient 14, remainder 2, out_valid exactly 65 edges after acceptance.
REQ-034 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFFFFFFFFFD, remainder 0xFFFFFFFFFFFFFFFF.
REQ-035 SHALL cover: 5/0 (signed and unsigned) -> quotient 0xFFFFFFFFFFFFFFFF, remainder 5; latency 1 cycle with the macro, 65 without.
REQ-036 SHALL cover: signed 0x8000000000000000 / -1 -> quotient 0x8000000000000000, remainder 0; word signed 0x80000000 / 0xFFFFFFFF -> quotient 0xFFFFFFFF80000000, remainder 0.
REQ-037 SHALL cover: flush at BUSY cycle 10 -> out_valid never asserts and in_ready is 1 the next cycle; reset mid-BUSY gives the same outcome.
REQ-038 SHALL cover: out_ready held low 5 cycles in DONE -> results and out_valid stay stable, and in_ready stays 0 until the cycle after the handshake.
